// File: rtl/innerloop_cmd_issuer.sv
// Initiator side of the innerloop ap_ctrl_hs handshake: queues loop commands, issues them one at a
// time to the callee, waits for completion (with optional timeout) and returns one result per command.
module innerloop_cmd_issuer #(
  parameter int LEN_DWIDTH = 32,
  parameter int INC_DWIDTH = 29,
  parameter int CMD_DEPTH  = 4,
  parameter int TIMEOUT_W  = 16
) (
  input  logic                    ap_clk,
  input  logic                    ap_rstn,
  // Command and result ports use valid/ready: a beat transfers on a clock edge where both are high;
  // the producer holds valid and payload stable until that edge.
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [LEN_DWIDTH-1:0]   cmd_init,
  input  logic [LEN_DWIDTH-1:0]   cmd_len,
  input  logic [INC_DWIDTH+2:0]   cmd_inc,
  input  logic [TIMEOUT_W-1:0]    timeout_cycles,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [31:0]             res_return,
  output logic [31:0]             res_cnt,
  output logic                    res_timeout,
  output logic                    busy,
  output logic                    ap_start,
  input  logic                    ap_ready,
  input  logic                    ap_done,
  input  logic                    ap_idle,
  input  logic [31:0]             ap_return,
  output logic [LEN_DWIDTH-1:0]   loop_init,
  output logic [LEN_DWIDTH-1:0]   loop_len,
  output logic [INC_DWIDTH+2:0]   loop_inc,
  input  logic [31:0]             loop_cnt,
  output logic [2:0]              dbg_state
);

  localparam int PTR_W = $clog2(CMD_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_PUSH  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t                state;
  logic [LEN_DWIDTH-1:0] mem_init [CMD_DEPTH];
  logic [LEN_DWIDTH-1:0] mem_len  [CMD_DEPTH];
  logic [INC_DWIDTH+2:0] mem_inc  [CMD_DEPTH];
  logic [PTR_W:0]        wr_ptr;
  logic [PTR_W:0]        rd_ptr;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  push;
  logic [TIMEOUT_W-1:0]  wait_cnt;
  logic                  timeout_hit;
  logic                  drain_pending;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign cmd_ready  = ~fifo_full;
  assign push       = cmd_valid & cmd_ready;
  assign busy       = (state != S_IDLE) || !fifo_empty;
  assign dbg_state  = state;

  assign timeout_hit = (timeout_cycles != '0) &&
                       (wait_cnt == timeout_cycles - TIMEOUT_W'(1));

  always_ff @(posedge ap_clk) begin
    if (push) begin
      mem_init[wr_ptr[PTR_W-1:0]] <= cmd_init;
      mem_len[wr_ptr[PTR_W-1:0]]  <= cmd_len;
      mem_inc[wr_ptr[PTR_W-1:0]]  <= cmd_inc;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rstn) begin
    if (!ap_rstn) begin
      wr_ptr <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + 1'b1;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rstn) begin
    if (!ap_rstn) begin
      state         <= S_IDLE;
      ap_start      <= 1'b0;
      loop_init     <= '0;
      loop_len      <= '0;
      loop_inc      <= '0;
      res_valid     <= 1'b0;
      res_return    <= '0;
      res_cnt       <= '0;
      res_timeout   <= 1'b0;
      rd_ptr        <= '0;
      wait_cnt      <= '0;
      drain_pending <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!fifo_empty && ap_idle) begin
            loop_init <= mem_init[rd_ptr[PTR_W-1:0]];
            loop_len  <= mem_len[rd_ptr[PTR_W-1:0]];
            loop_inc  <= mem_inc[rd_ptr[PTR_W-1:0]];
            ap_start  <= 1'b1;
            state     <= S_START;
          end
        end
        S_START: begin
          if (ap_ready) begin
            ap_start <= 1'b0;
            rd_ptr   <= rd_ptr + 1'b1;
            wait_cnt <= '0;
            if (ap_done) begin
              res_return  <= ap_return;
              res_cnt     <= loop_cnt;
              res_timeout <= 1'b0;
              res_valid   <= 1'b1;
              state       <= S_PUSH;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (ap_done) begin
            res_return  <= ap_return;
            res_cnt     <= loop_cnt;
            res_timeout <= 1'b0;
            res_valid   <= 1'b1;
            state       <= S_PUSH;
          end else if (timeout_hit) begin
            // Callee still owns the command; its eventual ap_done must be swallowed.
            res_return    <= '0;
            res_cnt       <= '0;
            res_timeout   <= 1'b1;
            res_valid     <= 1'b1;
            drain_pending <= 1'b1;
            state         <= S_PUSH;
          end
        end
        S_PUSH: begin
          if (ap_done) begin
            drain_pending <= 1'b0;
          end
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= (drain_pending && !ap_done) ? S_DRAIN : S_IDLE;
          end
        end
        S_DRAIN: begin
          if (ap_done) begin
            drain_pending <= 1'b0;
            state         <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_innerloop_cmd_issuer.sv
// Directed bench for innerloop_cmd_issuer: the bench plays host, result consumer and callee,
// with hand-computed expectations checked inline in each scenario task.
module tb_innerloop_cmd_issuer;

  logic        ap_clk = 1'b0;
  logic        ap_rstn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_init = '0;
  logic [31:0] cmd_len = '0;
  logic [31:0] cmd_inc = '0;
  logic [15:0] timeout_cycles = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_return;
  logic [31:0] res_cnt;
  logic        res_timeout;
  logic        busy;
  logic        ap_start;
  logic        ap_ready = 1'b0;
  logic        ap_done = 1'b0;
  logic        ap_idle = 1'b1;
  logic [31:0] ap_return = '0;
  logic [31:0] loop_init;
  logic [31:0] loop_len;
  logic [31:0] loop_inc;
  logic [31:0] loop_cnt = '0;
  logic [2:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  innerloop_cmd_issuer dut (
    .ap_clk(ap_clk), .ap_rstn(ap_rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_init(cmd_init), .cmd_len(cmd_len), .cmd_inc(cmd_inc),
    .timeout_cycles(timeout_cycles),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_return(res_return), .res_cnt(res_cnt), .res_timeout(res_timeout),
    .busy(busy),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_idle(ap_idle),
    .ap_return(ap_return),
    .loop_init(loop_init), .loop_len(loop_len), .loop_inc(loop_inc),
    .loop_cnt(loop_cnt), .dbg_state(dbg_state)
  );

  always #5 ap_clk = ~ap_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the rising edge.
  task automatic tick();
    bit acc;
    acc = cmd_valid && cmd_ready;
    @(posedge ap_clk);
    #1;
    if (acc) cmd_valid = 1'b0;
  endtask

  task automatic push_cmd(input logic [31:0] init, input logic [31:0] len, input logic [31:0] inc);
    cmd_init  = init;
    cmd_len   = len;
    cmd_inc   = inc;
    cmd_valid = 1'b1;
    for (int i = 0; i < 50 && cmd_valid; i++) tick();
    if (cmd_valid) begin
      n_cmp++; n_err++;
      $display("FAIL push_cmd: command init=%0d not accepted within 50 cycles", init);
      cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (ap_start) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Callee: accept the start, finish done_after cycles later; returns at the cycle after ap_done.
  task automatic serve_one(input logic [31:0] ret, input logic [31:0] cnt, input int done_after,
                           output bit ok, output logic [31:0] got_init);
    wait_start(ok);
    got_init = loop_init;
    if (!ok) return;
    ap_ready = 1'b1;
    tick();
    ap_ready = 1'b0;
    repeat (done_after - 1) tick();
    ap_done   = 1'b1;
    ap_return = ret;
    loop_cnt  = cnt;
    tick();
    ap_done = 1'b0;
  endtask

  task automatic accept_result();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge ap_clk);
    #1;
    n_cmp++;
    if ({ap_start, res_valid, busy, res_timeout} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_ctrl: got start/valid/busy/tmo=%b expected 0000",
               {ap_start, res_valid, busy, res_timeout});
    end
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready);
    end
    n_cmp++;
    if ({loop_init, loop_len, loop_inc, res_return, res_cnt} !== '0) begin
      n_err++; $display("FAIL reset_data: got init=%0d ret=%0d cnt=%0d expected 0",
                        loop_init, res_return, res_cnt);
    end
    ap_rstn = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int extra;
    int early;
    extra = 0;
    early = 0;
    cmd_init = 5; cmd_len = 8; cmd_inc = 1; cmd_valid = 1'b1;   // cycle 0
    tick();                                                       // cycle 1
    n_cmp++;
    if (ap_start !== 1'b0) begin
      n_err++; $display("FAIL single_start_c1: got %b expected 0", ap_start);
    end
    tick();                                                       // cycle 2
    n_cmp++;
    if (ap_start !== 1'b1) begin
      n_err++; $display("FAIL single_start_c2: got %b expected 1", ap_start);
    end
    n_cmp++;
    if (loop_init !== 32'd5 || loop_len !== 32'd8 || loop_inc !== 32'd1) begin
      n_err++; $display("FAIL single_fields: got %0d/%0d/%0d expected 5/8/1",
                        loop_init, loop_len, loop_inc);
    end
    ap_ready = 1'b1;
    tick();                                                       // cycle 3
    ap_ready = 1'b0;
    for (int c = 3; c < 12; c++) begin
      if (ap_start) extra++;
      if (res_valid) early++;
      tick();
    end
    ap_done = 1'b1; ap_return = 3; loop_cnt = 8;                  // cycle 12
    tick();                                                       // cycle 13
    ap_done = 1'b0;
    n_cmp++;
    if (extra != 0 || early != 0) begin
      n_err++; $display("FAIL single_pulse: got extra_start=%0d early_valid=%0d expected 0/0",
                        extra, early);
    end
    n_cmp++;
    if (res_valid !== 1'b1 || res_return !== 32'd3 || res_cnt !== 32'd8 || res_timeout !== 1'b0) begin
      n_err++; $display("FAIL single_result: got v=%b ret=%0d cnt=%0d tmo=%b expected 1/3/8/0",
                        res_valid, res_return, res_cnt, res_timeout);
    end
    accept_result();
    n_cmp++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL single_idle: got valid=%b busy=%b expected 0/0", res_valid, busy);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [31:0] got;
    logic [31:0] exp;
    ap_idle = 1'b0;
    for (int i = 0; i < 5; i++) exp_q.push_back(32'(100 + i));
    for (int i = 0; i < 4; i++) push_cmd(32'(100 + i), 32'd10, 32'd2);
    n_cmp++;
    if (cmd_ready !== 1'b0) begin
      n_err++; $display("FAIL b2b_full_ready: got %b expected 0", cmd_ready);
    end
    cmd_init = 104; cmd_len = 10; cmd_inc = 2; cmd_valid = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (cmd_valid !== 1'b1 || ap_start !== 1'b0) begin
      n_err++; $display("FAIL b2b_hold: got pending=%b start=%b expected 1/0", cmd_valid, ap_start);
    end
    ap_idle = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp = exp_q.pop_front();
      serve_one(exp + 100, 32'(i), 3, ok, got);
      n_cmp++;
      if (!ok || got !== exp) begin
        n_err++; $display("FAIL b2b_issue%0d: got started=%b init=%0d expected 1/%0d", i, ok, got, exp);
      end
      n_cmp++;
      if (res_valid !== 1'b1 || res_return !== exp + 100 || res_cnt !== 32'(i)) begin
        n_err++; $display("FAIL b2b_result%0d: got v=%b ret=%0d cnt=%0d expected 1/%0d/%0d",
                          i, res_valid, res_return, res_cnt, exp + 100, i);
      end
      accept_result();
    end
    n_cmp++;
    if (busy !== 1'b0 || cmd_valid !== 1'b0) begin
      n_err++; $display("FAIL b2b_end: got busy=%b pending=%b expected 0/0", busy, cmd_valid);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int bad;
    bad = 0;
    timeout_cycles = 4;
    push_cmd(32'd7, 32'd3, 32'd1);
    push_cmd(32'd8, 32'd3, 32'd1);
    wait_start(ok);
    ap_ready = 1'b1;
    tick();                       // R+1, first WAIT cycle
    ap_ready = 1'b0;
    repeat (3) tick();            // R+4, fourth WAIT cycle
    n_cmp++;
    if (!ok || res_valid !== 1'b0) begin
      n_err++; $display("FAIL tmo_early: got started=%b valid=%b expected 1/0", ok, res_valid);
    end
    tick();                       // R+5
    n_cmp++;
    if (res_valid !== 1'b1 || res_timeout !== 1'b1 || res_return !== 0 || res_cnt !== 0) begin
      n_err++; $display("FAIL tmo_result: got v=%b tmo=%b ret=%0d cnt=%0d expected 1/1/0/0",
                        res_valid, res_timeout, res_return, res_cnt);
    end
    accept_result();
    for (int i = 0; i < 5; i++) begin
      if (ap_start || res_valid) bad++;
      tick();
    end
    ap_done = 1'b1; ap_return = 32'hdead; loop_cnt = 32'd99;   // late done, must be dropped
    tick();
    ap_done = 1'b0;
    if (ap_start || res_valid) bad++;
    n_cmp++;
    if (bad != 0) begin
      n_err++; $display("FAIL tmo_drain_hold: got %0d cycles with start/valid expected 0", bad);
    end
    tick();
    n_cmp++;
    if (ap_start !== 1'b1 || loop_init !== 32'd8) begin
      n_err++; $display("FAIL tmo_next_start: got start=%b init=%0d expected 1/8", ap_start, loop_init);
    end
    ap_ready = 1'b1;
    tick();
    ap_ready = 1'b0;
    ap_done = 1'b1; ap_return = 55; loop_cnt = 2;
    tick();
    ap_done = 1'b0;
    n_cmp++;
    if (res_valid !== 1'b1 || res_timeout !== 1'b0 || res_return !== 32'd55) begin
      n_err++; $display("FAIL tmo_next_result: got v=%b tmo=%b ret=%0d expected 1/0/55",
                        res_valid, res_timeout, res_return);
    end
    accept_result();
    timeout_cycles = 0;
  endtask

  task automatic test_done_at_boundary();
    bit ok;
    logic [31:0] got;
    timeout_cycles = 4;
    push_cmd(32'd9, 32'd4, 32'd1);
    serve_one(32'd77, 32'd4, 4, ok, got);
    n_cmp++;
    if (!ok || res_valid !== 1'b1 || res_timeout !== 1'b0 || res_return !== 32'd77 || res_cnt !== 32'd4) begin
      n_err++; $display("FAIL bound_result: got v=%b tmo=%b ret=%0d cnt=%0d expected 1/0/77/4",
                        res_valid, res_timeout, res_return, res_cnt);
    end
    accept_result();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL bound_no_drain: got busy=%b expected 0", busy);
    end
    timeout_cycles = 0;
  endtask

  task automatic test_backpressure();
    bit ok;
    int bad;
    logic [31:0] got;
    bad = 0;
    push_cmd(32'd21, 32'd1, 32'd1);
    push_cmd(32'd22, 32'd1, 32'd1);
    serve_one(32'd31, 32'd1, 2, ok, got);
    for (int i = 0; i < 20; i++) begin
      if (res_valid !== 1'b1 || res_return !== 32'd31 || res_cnt !== 32'd1 || ap_start !== 1'b0) bad++;
      tick();
    end
    n_cmp++;
    if (!ok || got !== 32'd21 || bad != 0) begin
      n_err++; $display("FAIL bp_stable: got started=%b init=%0d unstable=%0d expected 1/21/0",
                        ok, got, bad);
    end
    accept_result();
    n_cmp++;
    if (ap_start !== 1'b0) begin
      n_err++; $display("FAIL bp_idle_cycle: got start=%b expected 0", ap_start);
    end
    tick();
    n_cmp++;
    if (ap_start !== 1'b1 || loop_init !== 32'd22) begin
      n_err++; $display("FAIL bp_next_start: got start=%b init=%0d expected 1/22", ap_start, loop_init);
    end
    serve_one(32'd32, 32'd1, 1, ok, got);
    n_cmp++;
    if (res_valid !== 1'b1 || res_return !== 32'd32) begin
      n_err++; $display("FAIL bp_next_result: got v=%b ret=%0d expected 1/32", res_valid, res_return);
    end
    accept_result();
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    int bad;
    bad = 0;
    push_cmd(32'd40, 32'd1, 32'd1);
    wait_start(ok);
    ap_ready = 1'b1;
    tick();
    ap_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_cmd(32'(41 + i), 32'd1, 32'd1);
    ap_rstn = 1'b0;
    #1;
    n_cmp++;
    if (!ok || ap_start !== 1'b0 || busy !== 1'b0 || res_valid !== 1'b0 || cmd_ready !== 1'b1 ||
        loop_init !== 32'd0) begin
      n_err++; $display("FAIL rst_mid: got started=%b start=%b busy=%b valid=%b ready=%b init=%0d expected 1/0/0/0/1/0",
                        ok, ap_start, busy, res_valid, cmd_ready, loop_init);
    end
    @(posedge ap_clk);
    #1;
    ap_rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ap_start !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++; $display("FAIL rst_release: got %0d cycles with start/busy or not ready expected 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_timeout();
    test_done_at_boundary();
    test_backpressure();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
